// File: rtl/noc_pkg.sv
// Shared NoC link types and constants.
// Used by node_link_fifo and its testbench.
package noc_pkg;

    localparam int FLIT_W = 32;
    localparam int STAT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/link_fifo.sv
// Register-based FIFO with wrap-around pointers and an occupancy count.
// DEPTH need not be a power of two; the pointers wrap explicitly at DEPTH-1.
module link_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // Guarded locally so the storage can never over- or under-run.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (rd_en) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_link_fifo.sv
// Buffered enable/ack link between two NoC nodes.
// Optional counters enabled by defining NODE_LINK_STATS_EN.
module node_link_fifo #(
    parameter int FLIT_W = noc_pkg::FLIT_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] down_flit,
    input  logic              down_enable,
    output logic              down_ack,
    output logic [FLIT_W-1:0] up_flit,
    output logic              up_enable,
    input  logic              up_ack
`ifdef NODE_LINK_STATS_EN
    ,
    output logic [noc_pkg::STAT_W-1:0] stat_xfer,
    output logic [noc_pkg::STAT_W-1:0] stat_stall
`endif
);

    import noc_pkg::*;

    logic push;
    logic pop;
    logic full;
    logic empty;

    // Ack depends on occupancy only, so a pop cannot free a slot in the same cycle.
    assign down_ack  = !rst && !full;
    assign up_enable = !empty;
    assign push      = down_enable && down_ack;
    assign pop       = up_enable && up_ack;

    link_fifo #(
        .W     (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (down_flit),
        .pop   (pop),
        .dout  (up_flit),
        .full  (full),
        .empty (empty)
    );

`ifdef NODE_LINK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfer  <= '0;
            stat_stall <= '0;
        end else begin
            if (pop) begin
                stat_xfer <= stat_xfer + STAT_W'(1);
            end
            if (up_enable && !up_ack) begin
                stat_stall <= stat_stall + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_node_link_fifo.sv
// Directed self-checking bench for node_link_fifo (DEPTH=4 and DEPTH=3 instances).
module tb_node_link_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] down_flit;
    logic        down_enable;
    logic        down_ack;
    logic [31:0] up_flit;
    logic        up_enable;
    logic        up_ack;

    logic        s_rst;
    logic [31:0] s_flit;
    logic        s_en;
    logic        s_dack;
    logic [31:0] s_uflit;
    logic        s_uen;
    logic        s_ack;

`ifdef NODE_LINK_STATS_EN
    logic [31:0] stat_xfer;
    logic [31:0] stat_stall;
    logic [31:0] s_xfer;
    logic [31:0] s_stall;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    node_link_fifo #(.FLIT_W(32), .DEPTH(4)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .down_flit   (down_flit),
        .down_enable (down_enable),
        .down_ack    (down_ack),
        .up_flit     (up_flit),
        .up_enable   (up_enable),
        .up_ack      (up_ack)
`ifdef NODE_LINK_STATS_EN
        ,
        .stat_xfer   (stat_xfer),
        .stat_stall  (stat_stall)
`endif
    );

    node_link_fifo #(.FLIT_W(32), .DEPTH(3)) u_str (
        .clk         (clk),
        .rst         (s_rst),
        .down_flit   (s_flit),
        .down_enable (s_en),
        .down_ack    (s_dack),
        .up_flit     (s_uflit),
        .up_enable   (s_uen),
        .up_ack      (s_ack)
`ifdef NODE_LINK_STATS_EN
        ,
        .stat_xfer   (s_xfer),
        .stat_stall  (s_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        down_enable = 1'b1;
        down_flit = 32'h1234_5678;
        up_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (down_ack !== 1'b0) begin
                errors++;
                $display("FAIL reset_down_ack: got %b want 0", down_ack);
            end
            checks++;
            if (up_enable !== 1'b0) begin
                errors++;
                $display("FAIL reset_up_enable: got %b want 0", up_enable);
            end
        end
        rst = 1'b0;
        down_enable = 1'b0;
        #1;
        checks++;
        if (down_ack !== 1'b1) begin
            errors++;
            $display("FAIL release_down_ack: got %b want 1", down_ack);
        end
        tick();
        checks++;
        if (up_enable !== 1'b0) begin
            errors++;
            $display("FAIL release_up_enable: got %b want 0", up_enable);
        end
`ifdef NODE_LINK_STATS_EN
        checks++;
        if (stat_xfer !== 32'd0 || stat_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_xfer, stat_stall);
        end
`endif
    endtask

    task automatic test_single();
        down_flit = 32'hA5A5_0001;
        down_enable = 1'b1;
        up_ack = 1'b0;
        #1;
        checks++;
        if (up_enable !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass: got %b want 0", up_enable);
        end
        tick();
        down_enable = 1'b0;
        checks++;
        if (up_enable !== 1'b1 || up_flit !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL single_out: got %b/%h want 1/a5a50001", up_enable, up_flit);
        end
        up_ack = 1'b1;
        tick();
        up_ack = 1'b0;
        checks++;
        if (up_enable !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got %b want 0", up_enable);
        end
    endtask

    task automatic test_fill();
        up_ack = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            down_flit = 32'(i);
            down_enable = 1'b1;
            #1;
            checks++;
            if (down_ack !== 1'b1) begin
                errors++;
                $display("FAIL fill_ack_%0d: got %b want 1", i, down_ack);
            end
            tick();
        end
        down_flit = 32'd5;
        checks++;
        if (down_ack !== 1'b0) begin
            errors++;
            $display("FAIL full_ack: got %b want 0", down_ack);
        end
        tick();
        checks++;
        if (down_ack !== 1'b0 || up_flit !== 32'd1) begin
            errors++;
            $display("FAIL full_hold: got %b/%h want 0/1", down_ack, up_flit);
        end
        up_ack = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if (up_enable !== 1'b1 || up_flit !== 32'(k)) begin
                errors++;
                $display("FAIL drain_%0d: got %b/%h want 1/%h", k, up_enable, up_flit, k);
            end
            if (k == 1) begin
                checks++;
                if (down_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL full_pop_ack: got %b want 0", down_ack);
                end
            end
            if (k == 2) begin
                checks++;
                if (down_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL after_pop_ack: got %b want 1", down_ack);
                end
            end
            tick();
            if (k == 2) down_enable = 1'b0;
        end
        up_ack = 1'b0;
        checks++;
        if (up_enable !== 1'b0) begin
            errors++;
            $display("FAIL fill_empty: got %b want 0", up_enable);
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        up_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            down_flit = 32'h10 + 32'(i);
            down_enable = 1'b1;
            tick();
        end
        down_enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (up_enable !== 1'b1 || up_flit !== 32'h10) begin
            errors++;
            $display("FAIL mid_buffered: got %b/%h want 1/10", up_enable, up_flit);
        end
`ifdef NODE_LINK_STATS_EN
        checks++;
        if (stat_stall !== 32'd5 || stat_xfer !== 32'd0) begin
            errors++;
            $display("FAIL mid_stats: got %0d/%0d want 0/5", stat_xfer, stat_stall);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (up_enable !== 1'b0) begin
            errors++;
            $display("FAIL mid_flush: got %b want 0", up_enable);
        end
`ifdef NODE_LINK_STATS_EN
        checks++;
        if (stat_stall !== 32'd0 || stat_xfer !== 32'd0) begin
            errors++;
            $display("FAIL mid_stats_clr: got %0d/%0d want 0/0", stat_xfer, stat_stall);
        end
`endif
        down_flit = 32'hDEAD_BEEF;
        down_enable = 1'b1;
        tick();
        down_enable = 1'b0;
        checks++;
        if (up_enable !== 1'b1 || up_flit !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL mid_roundtrip: got %b/%h want 1/deadbeef", up_enable, up_flit);
        end
        up_ack = 1'b1;
        tick();
        up_ack = 1'b0;
        checks++;
        if (up_enable !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain: got %b want 0", up_enable);
        end
`ifdef NODE_LINK_STATS_EN
        checks++;
        if (stat_xfer !== 32'd1) begin
            errors++;
            $display("FAIL mid_xfer: got %0d want 1", stat_xfer);
        end
`endif
    endtask

    task automatic test_stream();
        int exp_out = 0;
        int cycles = 0;
        s_rst = 1'b1;
        s_en = 1'b0;
        s_ack = 1'b0;
        s_flit = '0;
        tick();
        tick();
        s_rst = 1'b0;
        s_en = 1'b1;
        s_ack = 1'b1;
        #1;
        while (exp_out < 100 && cycles < 300) begin
            logic pushed;
            pushed = s_en && s_dack;
            if (s_uen && s_ack) begin
                checks++;
                if (s_uflit !== 32'(exp_out)) begin
                    errors++;
                    $display("FAIL stream_data: got %0d want %0d", s_uflit, exp_out);
                end
                exp_out++;
            end
            tick();
            cycles++;
            if (pushed) begin
                s_flit = s_flit + 32'd1;
                if (s_flit == 32'd100) s_en = 1'b0;
            end
        end
        checks++;
        if (cycles != 101 || exp_out != 100) begin
            errors++;
            $display("FAIL stream_rate: got %0d cycles/%0d flits want 101/100", cycles, exp_out);
        end
        s_ack = 1'b0;
        checks++;
        if (s_uen !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty: got %b want 0", s_uen);
        end
    endtask

    initial begin
        rst = 1'b1;
        down_flit = '0;
        down_enable = 1'b0;
        up_ack = 1'b0;
        s_rst = 1'b1;
        s_flit = '0;
        s_en = 1'b0;
        s_ack = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_mid_reset();
        test_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
